// File: rtl/frogger_pkg.sv
// Shared types and widths for the Frogger game-flow logic: state codes, output widths
// and the level-dependent car-move divisor.
package frogger_pkg;

  localparam int STATE_W = 3;
  localparam int LIVES_W = 3;
  localparam int LEVEL_W = 4;
  localparam int TIMER_W = 8;
  localparam int PHASE_W = 8;
  localparam int DIV_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    DEATH     = 3'd2,
    LEVEL_UP  = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  // Cars speed up by one frame per level but never move faster than once per frame.
  function automatic logic [DIV_W-1:0] move_divisor(input int base_div,
                                                    input logic [LEVEL_W-1:0] level);
    int diff;
    diff = base_div - int'(level);
    if (diff < 1) diff = 1;
    return DIV_W'(diff);
  endfunction

endpackage

// File: rtl/frogger_tick_div.sv
// Programmable frame-tick divider: pulses on the divisor-th enabled tick after a clear,
// in the same cycle as that tick.
module frogger_tick_div
  import frogger_pkg::*;
(
  input  logic             i_Clk,
  input  logic             reset,
  input  logic             i_Clear,
  input  logic             i_Enable,
  input  logic             i_Tick,
  input  logic [DIV_W-1:0] i_Divisor,
  output logic             o_Pulse
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;
  logic             terminal;

  // A divisor of 0 behaves like 1; the widened add keeps count 255 from wrapping.
  always_comb begin
    terminal = ({1'b0, count_q} + {{DIV_W{1'b0}}, 1'b1}) >= {1'b0, i_Divisor};
    o_Pulse  = i_Enable && i_Tick && terminal;
    count_d  = count_q;
    if (i_Clear) begin
      count_d = '0;
    end else if (i_Enable && i_Tick) begin
      count_d = terminal ? '0 : count_q + DIV_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frogger_game_sequencer.sv
// Frogger game-flow controller: IDLE/PLAY/DEATH/LEVEL_UP/GAME_OVER, lives, level and car pacing.
// Define FROGGER_TIMER_EN to add the per-life countdown that kills the frog when it runs out.
module frogger_game_sequencer
  import frogger_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int MAX_LEVEL    = 7,
  parameter int BASE_DIV     = 8,
  parameter int DEATH_FRAMES = 30,
  parameter int LEVEL_FRAMES = 30,
  parameter int TIMER_FRAMES = 255
) (
  input  logic               i_Clk,
  input  logic               reset,
  input  logic               i_Start,
  input  logic               i_Frame_Tick,
  input  logic               i_Hit,
  input  logic               i_Goal,
  output logic               o_Game_Active,
  output logic               o_Respawn,
  output logic               o_Move_Tick,
  output logic [LIVES_W-1:0] o_Lives,
  output logic [LEVEL_W-1:0] o_Level,
  output logic [STATE_W-1:0] o_State,
  output logic [TIMER_W-1:0] o_Timer
);

  state_t             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               respawn_q, respawn_d;
  logic               active_q;
  logic               state_entry;
  logic               phase_done;
  logic               timer_expire;

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    level_d   = level_q;
    phase_d   = phase_q;
    respawn_d = 1'b0;

    phase_done = 1'b0;
    if (state_q == DEATH) begin
      phase_done = i_Frame_Tick && (phase_q == PHASE_W'(DEATH_FRAMES - 1));
    end else if (state_q == LEVEL_UP) begin
      phase_done = i_Frame_Tick && (phase_q == PHASE_W'(LEVEL_FRAMES - 1));
    end

    if (i_Frame_Tick && (state_q == DEATH || state_q == LEVEL_UP)) begin
      phase_d = phase_q + PHASE_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (i_Start) begin
          state_d   = PLAY;
          lives_d   = LIVES_W'(LIVES);
          level_d   = '0;
          respawn_d = 1'b1;
        end
      end
      // A hit (or the life timer running out) takes priority over reaching the goal.
      PLAY: begin
        if (i_Hit || timer_expire) begin
          state_d = DEATH;
          lives_d = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
        end else if (i_Goal) begin
          state_d = LEVEL_UP;
        end
      end
      DEATH: begin
        if (phase_done) begin
          if (lives_q == '0) begin
            state_d = GAME_OVER;
          end else begin
            state_d   = PLAY;
            respawn_d = 1'b1;
          end
        end
      end
      LEVEL_UP: begin
        if (phase_done) begin
          state_d   = PLAY;
          respawn_d = 1'b1;
          if (int'(level_q) < MAX_LEVEL) begin
            level_d = level_q + LEVEL_W'(1);
          end else begin
            level_d = LEVEL_W'(MAX_LEVEL);
          end
        end
      end
      GAME_OVER: begin
        lives_d = '0;
        if (i_Start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every state starts counting from zero; the tick that caused the change is not carried over.
    state_entry = (state_d != state_q);
    if (state_entry) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lives_q   <= '0;
      level_q   <= '0;
      phase_q   <= '0;
      respawn_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      phase_q   <= phase_d;
      respawn_q <= respawn_d;
      active_q  <= (state_d == PLAY);
    end
  end

`ifdef FROGGER_TIMER_EN
  logic [TIMER_W-1:0] timer_q, timer_d;

  assign timer_expire = (state_q == PLAY) && i_Frame_Tick && (timer_q == TIMER_W'(1));

  always_comb begin
    timer_d = timer_q;
    if (state_d == PLAY && state_q != PLAY) begin
      timer_d = TIMER_W'(TIMER_FRAMES);
    end else if (state_q == PLAY && i_Frame_Tick && timer_q != '0) begin
      timer_d = timer_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign o_Timer = timer_q;
`else
  logic unused_timer_cfg;

  assign timer_expire     = 1'b0;
  assign o_Timer          = '0;
  assign unused_timer_cfg = ^TIMER_FRAMES;
`endif

  frogger_tick_div u_move_div (
    .i_Clk     (i_Clk),
    .reset     (reset),
    .i_Clear   (state_entry),
    .i_Enable  (state_q == PLAY),
    .i_Tick    (i_Frame_Tick),
    .i_Divisor (move_divisor(BASE_DIV, level_q)),
    .o_Pulse   (o_Move_Tick)
  );

  assign o_Game_Active = active_q;
  assign o_Respawn     = respawn_q;
  assign o_Lives       = lives_q;
  assign o_Level       = level_q;
  assign o_State       = state_q;

endmodule

// File: tb/tb_frogger_game_sequencer.sv
// Self-checking bench for frogger_game_sequencer: directed game scenarios followed by
// randomized play, all checked against a behavioural game model.
module tb_frogger_game_sequencer;

  localparam int LIVES        = 3;
  localparam int MAX_LEVEL    = 7;
  localparam int BASE_DIV     = 8;
  localparam int DEATH_FRAMES = 30;
  localparam int LEVEL_FRAMES = 30;
  localparam int TB_TIMER     = 40;
`ifdef FROGGER_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  localparam int S_IDLE = 0, S_PLAY = 1, S_DEATH = 2, S_LEVEL_UP = 3, S_GAME_OVER = 4;

  logic       i_Clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_Start = 1'b0;
  logic       i_Frame_Tick = 1'b0;
  logic       i_Hit = 1'b0;
  logic       i_Goal = 1'b0;
  logic       o_Game_Active;
  logic       o_Respawn;
  logic       o_Move_Tick;
  logic [2:0] o_Lives;
  logic [3:0] o_Level;
  logic [2:0] o_State;
  logic [7:0] o_Timer;

  int n_checks = 0;
  int n_bad = 0;
  int move_seen = 0;

  // Reference game state
  int m_state = S_IDLE;
  int m_lives = 0;
  int m_level = 0;
  int m_wait = 0;
  int m_play_ticks = 0;
  int m_timer = 0;
  int m_respawn = 0;

  frogger_game_sequencer #(
    .LIVES(LIVES), .MAX_LEVEL(MAX_LEVEL), .BASE_DIV(BASE_DIV),
    .DEATH_FRAMES(DEATH_FRAMES), .LEVEL_FRAMES(LEVEL_FRAMES), .TIMER_FRAMES(TB_TIMER)
  ) dut (
    .i_Clk(i_Clk), .reset(reset), .i_Start(i_Start), .i_Frame_Tick(i_Frame_Tick),
    .i_Hit(i_Hit), .i_Goal(i_Goal), .o_Game_Active(o_Game_Active), .o_Respawn(o_Respawn),
    .o_Move_Tick(o_Move_Tick), .o_Lives(o_Lives), .o_Level(o_Level), .o_State(o_State),
    .o_Timer(o_Timer)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic void enter_play();
    m_state      = S_PLAY;
    m_respawn    = 1;
    m_play_ticks = 0;
    if (TIMER_EN) m_timer = TB_TIMER;
  endfunction

  function automatic void model_step(input bit st, input bit ft, input bit hit,
                                     input bit goal, input bit rst);
    bit expire;
    if (rst) begin
      m_state = S_IDLE; m_lives = 0; m_level = 0; m_wait = 0;
      m_play_ticks = 0; m_timer = 0; m_respawn = 0;
      return;
    end
    m_respawn = 0;
    case (m_state)
      S_IDLE: if (st) begin
        enter_play();
        m_lives = LIVES;
        m_level = 0;
      end
      S_PLAY: begin
        expire = TIMER_EN && ft && (m_timer == 1);
        if (ft) m_play_ticks++;
        if (TIMER_EN && ft && m_timer > 0) m_timer--;
        if (hit || expire) begin
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          m_state = S_DEATH;
          m_wait  = DEATH_FRAMES;
        end else if (goal) begin
          m_state = S_LEVEL_UP;
          m_wait  = LEVEL_FRAMES;
        end
      end
      S_DEATH: if (ft) begin
        m_wait--;
        if (m_wait == 0) begin
          if (m_lives == 0) m_state = S_GAME_OVER;
          else enter_play();
        end
      end
      S_LEVEL_UP: if (ft) begin
        m_wait--;
        if (m_wait == 0) begin
          m_level = (m_level + 1 > MAX_LEVEL) ? MAX_LEVEL : m_level + 1;
          enter_play();
        end
      end
      default: if (st) m_state = S_IDLE;
    endcase
  endfunction

  // One clock cycle: drive, check the same-cycle move pulse, clock, check registered outputs.
  task automatic applyStimulus(input bit st, input bit ft, input bit hit,
                               input bit goal, input bit rst);
    int div;
    int exp_move;
    i_Start = st; i_Frame_Tick = ft; i_Hit = hit; i_Goal = goal; reset = rst;
    #2;
    div = BASE_DIV - m_level;
    if (div < 1) div = 1;
    exp_move = (!rst && m_state == S_PLAY && ft && ((m_play_ticks + 1) % div == 0)) ? 1 : 0;
    checkOutput("move_tick", int'(o_Move_Tick), exp_move);
    if (o_Move_Tick) move_seen++;
    @(posedge i_Clk);
    model_step(st, ft, hit, goal, rst);
    @(negedge i_Clk);
    checkOutput("state", int'(o_State), m_state);
    checkOutput("lives", int'(o_Lives), m_lives);
    checkOutput("level", int'(o_Level), m_level);
    checkOutput("active", int'(o_Game_Active), (m_state == S_PLAY) ? 1 : 0);
    checkOutput("respawn", int'(o_Respawn), m_respawn);
    checkOutput("timer", int'(o_Timer), TIMER_EN ? m_timer : 0);
  endtask

  task automatic quiet();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      quiet();
    end
  endtask

  initial begin
    int moves_before;
    bit st, ft, hit, goal, rst, busy;

    $display("[TB] start");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_state", int'(o_State), S_IDLE);
    checkOutput("rst_lives", int'(o_Lives), 0);
    quiet();

    // Game start
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_state", int'(o_State), S_PLAY);
    checkOutput("t1_lives", int'(o_Lives), 3);
    checkOutput("t1_respawn", int'(o_Respawn), 1);
    quiet();
    checkOutput("t1_respawn_end", int'(o_Respawn), 0);

    // Level-0 car pacing
    moves_before = move_seen;
    frame_ticks(16);
    checkOutput("t2_moves", move_seen - moves_before, 2);

    // Lose all lives
    for (int life = 3; life >= 1; life--) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("t3_death_lives", int'(o_Lives), life - 1);
      quiet();
      frame_ticks(DEATH_FRAMES);
    end
    checkOutput("t3_game_over", int'(o_State), S_GAME_OVER);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    quiet();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_idle", int'(o_State), S_IDLE);
    quiet();

    // Hit and goal together
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    quiet();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_state", int'(o_State), S_DEATH);
    checkOutput("t4_lives", int'(o_Lives), 2);
    checkOutput("t4_level", int'(o_Level), 0);
    quiet();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    quiet();

    // Climb to the top level, then one more goal
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    quiet();
    for (int lv = 0; lv < 8; lv++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      quiet();
      frame_ticks(LEVEL_FRAMES - 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_respawn", int'(o_Respawn), 1);
      quiet();
    end
    checkOutput("t5_level", int'(o_Level), 7);
    checkOutput("t5_state", int'(o_State), S_PLAY);
    checkOutput("t5_lives", int'(o_Lives), 3);
    moves_before = move_seen;
    frame_ticks(3);
    checkOutput("t5_moves", move_seen - moves_before, 3);

    // Death (by timer when enabled), then reset in the middle of DEATH
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    quiet();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    quiet();
    if (TIMER_EN) begin
      frame_ticks(TB_TIMER);
    end else begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      quiet();
    end
    checkOutput("t6_state", int'(o_State), S_DEATH);
    checkOutput("t6_lives", int'(o_Lives), 2);
    frame_ticks(5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t6_rst_state", int'(o_State), S_IDLE);
    checkOutput("t6_rst_respawn", int'(o_Respawn), 0);
    checkOutput("t6_rst_timer", int'(o_Timer), 0);
    quiet();

    // Random play; every event cycle is followed by a quiet cycle
    busy = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      st = 1'b0; ft = 1'b0; hit = 1'b0; goal = 1'b0; rst = 1'b0;
      if (!busy) begin
        if ($urandom_range(0, 399) == 0) begin
          rst = 1'b1;
        end else begin
          ft   = ($urandom_range(0, 1) == 1);
          hit  = ($urandom_range(0, 29) == 0);
          goal = ($urandom_range(0, 24) == 0);
          st   = ($urandom_range(0, 5) == 0);
        end
      end
      busy = st | ft | hit | goal | rst;
      applyStimulus(st, ft, hit, goal, rst);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
